// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control sequencer for the 4-bit accumulator computer.
//   Each instruction takes three cycles:
//     FETCH  - latch the program word into IR (only while run=1)
//     DECODE - decode IR and register the control word / jump decision
//     EXEC   - registered control word is presented to the datapath
//   Opcode F parks the FSM in HALT until reset.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   run        1 = sequence instructions, 0 = park in FETCH
//   prog_word  program word at current PC: [7:4] opcode, [3:0] operand
//   ab_flag    ALU A=B flag (zero condition), sampled in DECODE
//   cp         ALU carry-out, active-low, sampled in DECODE
//   ctrl       control word {Sel, Cn, S3..S0, M, Acc, RW, PCinc}
//   pc_load    load PC with pc_target (EXEC only)
//   pc_target  jump destination = IR operand
//   halted     HALT has been executed
//   state      current FSM state (debug)
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter logic [3:0] RESET_OPCODE = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] prog_word,
  input  logic       ab_flag,
  input  logic       cp,
  output logic [9:0] ctrl,
  output logic       pc_load,
  output logic [3:0] pc_target,
  output logic       halted,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [9:0] ctrl_q, ctrl_d;
  logic       pc_load_q, pc_load_d;
  logic       halted_q, halted_d;

  // Decoder outputs (combinational from IR and the datapath flags)
  logic [3:0] opcode;
  logic       dec_sel, dec_cn, dec_m, dec_acc, dec_rw, dec_pcinc, dec_jump;
  logic [3:0] dec_s;
  logic [9:0] dec_ctrl;

  assign opcode = ir_q[7:4];

  always_comb begin
    dec_sel  = 1'b0;
    dec_cn   = 1'b0;
    dec_m    = 1'b0;
    dec_acc  = 1'b0;
    dec_rw   = 1'b0;
    dec_s    = 4'b0000;
    dec_jump = 1'b0;
    unique case (opcode)
      4'h0: ;                                                       // NOP
      4'h1: begin dec_acc = 1'b1; dec_sel = 1'b1; dec_m = 1'b1; dec_s = 4'b1010; end // LDA
      4'h2: begin dec_acc = 1'b1;                 dec_m = 1'b1; dec_s = 4'b1010; end // LDI
      4'h3: dec_rw = 1'b1;                                          // STA
      4'h4: begin dec_acc = 1'b1; dec_sel = 1'b1; dec_s = 4'b1001; dec_cn = 1'b1; end // ADD
      4'h5: begin dec_acc = 1'b1; dec_sel = 1'b1; dec_s = 4'b0110; end              // SUB
      4'h6: begin dec_acc = 1'b1; dec_sel = 1'b1; dec_m = 1'b1; dec_s = 4'b1011; end // AND
      4'h7: begin dec_acc = 1'b1; dec_sel = 1'b1; dec_m = 1'b1; dec_s = 4'b1110; end // OR
      4'h8: begin dec_acc = 1'b1; dec_sel = 1'b1; dec_m = 1'b1; dec_s = 4'b0110; end // XOR
      4'h9: begin dec_acc = 1'b1;                 dec_m = 1'b1; dec_s = 4'b0000; end // NOT
      4'hA: begin dec_acc = 1'b1;                 dec_s = 4'b1001; dec_cn = 1'b1; end // ADDI
      4'hB: begin dec_sel = 1'b1;                 dec_s = 4'b0110; end              // CMP
      4'hC: dec_jump = 1'b1;                                        // JMP
      4'hD: dec_jump = ab_flag;                                     // JZ
      4'hE: dec_jump = ~cp;                                         // JC (carry active-low)
      4'hF: ;                                                       // HLT
      default: ;
    endcase
    // A taken jump replaces the increment; HLT must not move the PC either.
    dec_pcinc = ~dec_jump & (opcode != 4'hF);
    dec_ctrl  = {dec_sel, dec_cn, dec_s, dec_m, dec_acc, dec_rw, dec_pcinc};
  end

  // Next-state and registered-output logic. ctrl/pc_load default to 0 so they
  // are only nonzero for the single EXEC cycle loaded at the end of DECODE.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ctrl_d    = 10'd0;
    pc_load_d = 1'b0;
    halted_d  = halted_q;
    unique case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = prog_word;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl_d    = dec_ctrl;
        pc_load_d = dec_jump;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode == 4'hF) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= {RESET_OPCODE, 4'h0};
      ctrl_q    <= 10'd0;
      pc_load_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      pc_load_q <= pc_load_d;
      halted_q  <= halted_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign pc_load   = pc_load_q;
  assign pc_target = ir_q[3:0];
  assign halted    = halted_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] prog_word;
  logic       ab_flag;
  logic       cp;
  logic [9:0] ctrl;
  logic       pc_load;
  logic [3:0] pc_target;
  logic       halted;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  cpu_sequencer #(.RESET_OPCODE(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_word(prog_word),
    .ab_flag(ab_flag), .cp(cp), .ctrl(ctrl), .pc_load(pc_load),
    .pc_target(pc_target), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: ALU/control fields from the opcode table, jump rule from
  // the flags. Returns the EXEC-cycle control word and pc_load.
  function automatic void model(input logic [3:0] op, input logic ab, input logic c,
                                output logic [9:0] ectrl, output logic eload);
    logic acc, sel, m, cn, rw, taken, inc;
    logic [3:0] s;
    acc = 0; sel = 0; m = 0; cn = 0; rw = 0; s = 4'b0000;
    case (op)
      4'h1: {acc, sel, m, s}     = {3'b111, 4'b1010};
      4'h2: {acc, sel, m, s}     = {3'b101, 4'b1010};
      4'h3: rw = 1;
      4'h4: {acc, sel, m, s, cn} = {3'b110, 4'b1001, 1'b1};
      4'h5: {acc, sel, m, s, cn} = {3'b110, 4'b0110, 1'b0};
      4'h6: {acc, sel, m, s}     = {3'b111, 4'b1011};
      4'h7: {acc, sel, m, s}     = {3'b111, 4'b1110};
      4'h8: {acc, sel, m, s}     = {3'b111, 4'b0110};
      4'h9: {acc, sel, m, s}     = {3'b101, 4'b0000};
      4'hA: {acc, sel, m, s, cn} = {3'b100, 4'b1001, 1'b1};
      4'hB: {acc, sel, m, s, cn} = {3'b010, 4'b0110, 1'b0};
      default: ;
    endcase
    taken = (op == 4'hC) || (op == 4'hD && ab) || (op == 4'hE && !c);
    inc   = !taken && (op != 4'hF);
    ectrl = 10'd0;
    ectrl[0] = inc; ectrl[1] = rw; ectrl[2] = acc; ectrl[3] = m;
    ectrl[7:4] = s; ectrl[8] = cn; ectrl[9] = sel;
    eload = taken;
  endfunction

  // Drives one instruction starting in FETCH and records what was observed
  // after each of the three edges (DECODE, EXEC, following state).
  task automatic run_instr(input logic [7:0] w, input logic ab, input logic c,
                           input logic run_mid,
                           output logic [1:0] s1, output logic [9:0] c1,
                           output logic [1:0] s2, output logic [9:0] c2,
                           output logic l2, output logic [3:0] t2,
                           output logic [1:0] s3, output logic [9:0] c3,
                           output logic l3);
    prog_word = w; run = 1'b1; ab_flag = ab; cp = c;
    tick;
    s1 = state; c1 = ctrl;
    run = run_mid; prog_word = 8'($urandom);
    tick;
    s2 = state; c2 = ctrl; l2 = pc_load; t2 = pc_target;
    ab_flag = 1'($urandom); cp = 1'($urandom);
    tick;
    s3 = state; c3 = ctrl; l3 = pc_load;
    run = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    run = 1'b0; prog_word = 8'h00; ab_flag = 1'b0; cp = 1'b1;
    do_reset;
    checks++;
    if (state !== 2'b00 || ctrl !== 10'd0 || pc_load !== 1'b0 ||
        pc_target !== 4'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%b ctrl=%b pc_load=%b tgt=%h halted=%b, need 00/0/0/0/0",
               state, ctrl, pc_load, pc_target, halted);
    end
  endtask

  task automatic test_add;
    logic [1:0] s1, s2, s3; logic [9:0] c1, c2, c3; logic l2, l3; logic [3:0] t2;
    run_instr(8'h43, 1'b0, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (s1 !== 2'b01 || s2 !== 2'b10 || s3 !== 2'b00) begin
      errors++;
      $display("FAIL add_states: got %b %b %b, need 01 10 00", s1, s2, s3);
    end
    checks++;
    if (c2 !== 10'b1_1_1001_0_1_0_1) begin
      errors++;
      $display("FAIL add_ctrl: got %b, need 1110010101", c2);
    end
    checks++;
    if (c1 !== 10'd0 || c3 !== 10'd0) begin
      errors++;
      $display("FAIL add_width: ctrl before=%b after=%b, need 0 0", c1, c3);
    end
  endtask

  task automatic test_sub_sta;
    logic [1:0] s1, s2, s3; logic [9:0] c1, c2, c3; logic l2, l3; logic [3:0] t2;
    logic [1:0] u1, u2, u3; logic [9:0] d1, d2, d3; logic m2, m3; logic [3:0] v2;
    run_instr(8'h52, 1'b0, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    run_instr(8'h37, 1'b0, 1'b1, 1'b1, u1, d1, u2, d2, m2, v2, u3, d3, m3);
    checks++;
    if (c2[8] !== 1'b0 || c2[7:4] !== 4'b0110 || c2[2] !== 1'b1) begin
      errors++;
      $display("FAIL sub_ctrl: got %b, need Cn=0 S=0110 Acc=1", c2);
    end
    checks++;
    if (d2 !== 10'b00_0000_0_0_1_1) begin
      errors++;
      $display("FAIL sta_ctrl: got %b, need 0000000011", d2);
    end
    checks++;
    if ({s1, s2, s3, u1, u2, u3} !== {6'b011000, 6'b011000}) begin
      errors++;
      $display("FAIL sub_sta_seq: got %b %b %b %b %b %b, need 01 10 00 01 10 00",
               s1, s2, s3, u1, u2, u3);
    end
  endtask

  task automatic test_jumps;
    logic [1:0] s1, s2, s3; logic [9:0] c1, c2, c3; logic l2, l3; logic [3:0] t2;
    run_instr(8'hD9, 1'b1, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (l2 !== 1'b1 || t2 !== 4'h9 || c2[0] !== 1'b0 || l3 !== 1'b0) begin
      errors++;
      $display("FAIL jz_taken: load=%b tgt=%h inc=%b load_after=%b, need 1 9 0 0",
               l2, t2, c2[0], l3);
    end
    run_instr(8'hD9, 1'b0, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (l2 !== 1'b0 || c2[0] !== 1'b1) begin
      errors++;
      $display("FAIL jz_not_taken: load=%b inc=%b, need 0 1", l2, c2[0]);
    end
    run_instr(8'hE4, 1'b0, 1'b0, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (l2 !== 1'b1 || t2 !== 4'h4 || c2[0] !== 1'b0) begin
      errors++;
      $display("FAIL jc_taken: load=%b tgt=%h inc=%b, need 1 4 0", l2, t2, c2[0]);
    end
    run_instr(8'hE4, 1'b1, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (l2 !== 1'b0 || c2[0] !== 1'b1) begin
      errors++;
      $display("FAIL jc_not_taken: load=%b inc=%b, need 0 1", l2, c2[0]);
    end
    run_instr(8'hC5, 1'b0, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (l2 !== 1'b1 || t2 !== 4'h5 || c2 !== 10'd0) begin
      errors++;
      $display("FAIL jmp: load=%b tgt=%h ctrl=%b, need 1 5 0", l2, t2, c2);
    end
  endtask

  task automatic test_random;
    logic [1:0] s1, s2, s3; logic [9:0] c1, c2, c3; logic l2, l3; logic [3:0] t2;
    logic [9:0] ec; logic el; logic [7:0] w; logic ab, c;
    for (int i = 0; i < 60; i++) begin
      int idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        run = 1'b0; prog_word = 8'($urandom);
        tick;
        checks++;
        if (state !== 2'b00 || ctrl !== 10'd0 || pc_load !== 1'b0) begin
          errors++;
          $display("FAIL park[%0d]: state=%b ctrl=%b load=%b, need 00 0 0",
                   i, state, ctrl, pc_load);
        end
      end
      w  = {4'($urandom_range(0, 14)), 4'($urandom)};
      ab = 1'($urandom); c = 1'($urandom);
      model(w[7:4], ab, c, ec, el);
      run_instr(w, ab, c, 1'($urandom), s1, c1, s2, c2, l2, t2, s3, c3, l3);
      checks++;
      if (s1 !== 2'b01 || s2 !== 2'b10 || s3 !== 2'b00 || c1 !== 10'd0 ||
          c3 !== 10'd0 || l3 !== 1'b0) begin
        errors++;
        $display("FAIL rnd_seq[%0d] w=%h: states %b %b %b ctrl pre/post %b %b, need 01 10 00 0 0",
                 i, w, s1, s2, s3, c1, c3);
      end
      checks++;
      if (c2 !== ec || l2 !== el || t2 !== w[3:0]) begin
        errors++;
        $display("FAIL rnd_exec[%0d] w=%h ab=%b cp=%b: ctrl=%b load=%b tgt=%h, need %b %b %h",
                 i, w, ab, c, c2, l2, t2, ec, el, w[3:0]);
      end
    end
  endtask

  task automatic test_halt;
    logic [1:0] s1, s2, s3; logic [9:0] c1, c2, c3; logic l2, l3; logic [3:0] t2;
    int bad = 0;
    run_instr(8'hF0, 1'b0, 1'b1, 1'b1, s1, c1, s2, c2, l2, t2, s3, c3, l3);
    checks++;
    if (s2 !== 2'b10 || c2 !== 10'd0 || s3 !== 2'b11 || halted !== 1'b1) begin
      errors++;
      $display("FAIL hlt_enter: exec_state=%b exec_ctrl=%b state=%b halted=%b, need 10 0 11 1",
               s2, c2, s3, halted);
    end
    for (int k = 0; k < 20; k++) begin
      run = 1'b1; prog_word = 8'($urandom); ab_flag = 1'($urandom); cp = 1'($urandom);
      tick;
      if (state !== 2'b11 || ctrl !== 10'd0 || pc_load !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hlt_hold: %0d bad cycles of 20, need 0", bad);
    end
    run = 1'b0;
    do_reset;
    checks++;
    if (state !== 2'b00 || halted !== 1'b0 || ctrl !== 10'd0) begin
      errors++;
      $display("FAIL hlt_reset: state=%b halted=%b ctrl=%b, need 00 0 0", state, halted, ctrl);
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    prog_word = 8'h43; run = 1'b1; ab_flag = 1'b0; cp = 1'b1;
    tick;
    tick;
    checks++;
    if (state !== 2'b10 || ctrl !== 10'b1110010101) begin
      errors++;
      $display("FAIL mid_exec: state=%b ctrl=%b, need 10 1110010101", state, ctrl);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; run = 1'b0;
    checks++;
    if (state !== 2'b00 || ctrl !== 10'd0 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: state=%b ctrl=%b load=%b, need 00 0 0", state, ctrl, pc_load);
    end
    for (int k = 0; k < 5; k++) begin
      prog_word = 8'($urandom);
      tick;
      if (state !== 2'b00 || ctrl !== 10'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_park: %0d bad cycles of 5, need 0", bad);
    end
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0; prog_word = 8'h00; ab_flag = 1'b0; cp = 1'b1;
    tick;
    test_reset;
    test_add;
    test_sub_sta;
    test_jumps;
    test_random;
    test_halt;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
